// File: rtl/tl_fifo_pkg.sv
// tl_fifo_pkg: channel widths and occupancy-counter width helpers for tl_fifo
package tl_fifo_pkg;
  // A/B: opcode(3) param(3) size(4) source addr mask data corrupt(1)
  function automatic int tl_a_w(int sw, int aw, int dw);
    return 11 + sw + aw + dw / 8 + dw;
  endfunction
  function automatic int tl_b_w(int sw, int aw, int dw);
    return 11 + sw + aw + dw / 8 + dw;
  endfunction
  // C: opcode(3) param(3) size(4) source addr data corrupt(1)
  function automatic int tl_c_w(int sw, int aw, int dw);
    return 11 + sw + aw + dw;
  endfunction
  // D: opcode(3) param(2) size(4) source sink denied(1) data corrupt(1)
  function automatic int tl_d_w(int sw, int kw, int dw);
    return 11 + sw + kw + dw;
  endfunction
  // E: sink
  function automatic int tl_e_w(int kw);
    return kw;
  endfunction
  // Occupancy counter width; a wire channel still exposes a 1-bit count
  function automatic int tl_fifo_cnt_w(int depth);
    return depth == 0 ? 1 : $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/tl_fifo_channel.sv
// tl_fifo_channel: one TL channel buffer (wire, or circular FIFO with optional fall-through); TL_FIFO_WATERMARK_EN adds a high-water mark
module tl_fifo_channel
  import tl_fifo_pkg::*;
#(
  parameter int W = 8,
  parameter int DEPTH = 2,
  parameter int FALL_THROUGH = 0,
  localparam int CW = tl_fifo_cnt_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [W-1:0]  w_data,
  output logic          r_valid,
  input  logic          r_ready,
  output logic [W-1:0]  r_data,
  output logic [CW-1:0] count
`ifdef TL_FIFO_WATERMARK_EN
  ,
  input  logic          hwm_clear,
  output logic [CW-1:0] hwm
`endif
);
  if (DEPTH == 0) begin : g_wire
    assign r_valid = w_valid;
    assign w_ready = r_ready;
    assign r_data  = w_data;
    assign count   = '0;
`ifdef TL_FIFO_WATERMARK_EN
    assign hwm     = '0;
`endif
  end else begin : g_fifo
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] cnt, cnt_nxt;
    logic empty, bypass, push, pop, wr_en, rd_en;
    assign empty   = cnt == '0;
    assign bypass  = (FALL_THROUGH != 0) && empty;
    assign w_ready = cnt != CW'(DEPTH);
    assign r_valid = !empty || (bypass && w_valid);
    assign r_data  = bypass ? w_data : mem[rd_ptr];
    assign push    = w_valid && w_ready;
    assign pop     = r_valid && r_ready;
    assign wr_en   = push && !(bypass && pop);
    assign rd_en   = pop && !empty;
    assign cnt_nxt = cnt + CW'(wr_en) - CW'(rd_en);
    assign count   = cnt;
    // Storage is deliberately left unreset; only pointers/count define contents
    always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr] <= w_data;
    end
    // Pointers wrap at DEPTH-1 so non-power-of-two depths work
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
        if (rd_en) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
        cnt <= cnt_nxt;
      end
    end
`ifdef TL_FIFO_WATERMARK_EN
    // Track peak occupancy; clear snaps to the current count
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) hwm <= '0;
      else hwm <= hwm_clear ? cnt : (cnt_nxt > hwm ? cnt_nxt : hwm);
    end
`endif
  end
endmodule

// File: rtl/tl_fifo.sv
// tl_fifo: five independent TL channel buffers (A/C/E host->device, B/D device->host); TL_FIFO_WATERMARK_EN adds per-channel high-water marks
module tl_fifo
  import tl_fifo_pkg::*;
#(
  parameter int SourceWidth = 1,
  parameter int SinkWidth = 1,
  parameter int AddrWidth = 56,
  parameter int DataWidth = 64,
  parameter int ReqDepth = 2,
  parameter int PrbDepth = 2,
  parameter int RelDepth = 2,
  parameter int GntDepth = 2,
  parameter int AckDepth = 2,
  parameter int ReqFallThrough = 0,
  parameter int PrbFallThrough = 0,
  parameter int RelFallThrough = 0,
  parameter int GntFallThrough = 0,
  parameter int AckFallThrough = 0,
  localparam int a_w = tl_a_w(SourceWidth, AddrWidth, DataWidth),
  localparam int b_w = tl_b_w(SourceWidth, AddrWidth, DataWidth),
  localparam int c_w = tl_c_w(SourceWidth, AddrWidth, DataWidth),
  localparam int d_w = tl_d_w(SourceWidth, SinkWidth, DataWidth),
  localparam int e_w = tl_e_w(SinkWidth),
  localparam int req_cw = tl_fifo_cnt_w(ReqDepth),
  localparam int prb_cw = tl_fifo_cnt_w(PrbDepth),
  localparam int rel_cw = tl_fifo_cnt_w(RelDepth),
  localparam int gnt_cw = tl_fifo_cnt_w(GntDepth),
  localparam int ack_cw = tl_fifo_cnt_w(AckDepth)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              host_a_valid,
  input  logic [a_w-1:0]    host_a,
  output logic              host_a_ready,
  output logic              host_b_valid,
  output logic [b_w-1:0]    host_b,
  input  logic              host_b_ready,
  input  logic              host_c_valid,
  input  logic [c_w-1:0]    host_c,
  output logic              host_c_ready,
  output logic              host_d_valid,
  output logic [d_w-1:0]    host_d,
  input  logic              host_d_ready,
  input  logic              host_e_valid,
  input  logic [e_w-1:0]    host_e,
  output logic              host_e_ready,
  output logic              device_a_valid,
  output logic [a_w-1:0]    device_a,
  input  logic              device_a_ready,
  input  logic              device_b_valid,
  input  logic [b_w-1:0]    device_b,
  output logic              device_b_ready,
  output logic              device_c_valid,
  output logic [c_w-1:0]    device_c,
  input  logic              device_c_ready,
  input  logic              device_d_valid,
  input  logic [d_w-1:0]    device_d,
  output logic              device_d_ready,
  output logic              device_e_valid,
  output logic [e_w-1:0]    device_e,
  input  logic              device_e_ready,
  output logic [req_cw-1:0] req_count_o,
  output logic [prb_cw-1:0] prb_count_o,
  output logic [rel_cw-1:0] rel_count_o,
  output logic [gnt_cw-1:0] gnt_count_o,
  output logic [ack_cw-1:0] ack_count_o
`ifdef TL_FIFO_WATERMARK_EN
  ,
  input  logic              hwm_clear_i,
  output logic [req_cw-1:0] req_hwm_o,
  output logic [prb_cw-1:0] prb_hwm_o,
  output logic [rel_cw-1:0] rel_hwm_o,
  output logic [gnt_cw-1:0] gnt_hwm_o,
  output logic [ack_cw-1:0] ack_hwm_o
`endif
);
  tl_fifo_channel #(.W(a_w), .DEPTH(ReqDepth), .FALL_THROUGH(ReqFallThrough)) u_req (
    .clk_i, .rst_ni,
    .w_valid(host_a_valid), .w_ready(host_a_ready), .w_data(host_a),
    .r_valid(device_a_valid), .r_ready(device_a_ready), .r_data(device_a),
    .count(req_count_o)
`ifdef TL_FIFO_WATERMARK_EN
    , .hwm_clear(hwm_clear_i), .hwm(req_hwm_o)
`endif
  );
  tl_fifo_channel #(.W(b_w), .DEPTH(PrbDepth), .FALL_THROUGH(PrbFallThrough)) u_prb (
    .clk_i, .rst_ni,
    .w_valid(device_b_valid), .w_ready(device_b_ready), .w_data(device_b),
    .r_valid(host_b_valid), .r_ready(host_b_ready), .r_data(host_b),
    .count(prb_count_o)
`ifdef TL_FIFO_WATERMARK_EN
    , .hwm_clear(hwm_clear_i), .hwm(prb_hwm_o)
`endif
  );
  tl_fifo_channel #(.W(c_w), .DEPTH(RelDepth), .FALL_THROUGH(RelFallThrough)) u_rel (
    .clk_i, .rst_ni,
    .w_valid(host_c_valid), .w_ready(host_c_ready), .w_data(host_c),
    .r_valid(device_c_valid), .r_ready(device_c_ready), .r_data(device_c),
    .count(rel_count_o)
`ifdef TL_FIFO_WATERMARK_EN
    , .hwm_clear(hwm_clear_i), .hwm(rel_hwm_o)
`endif
  );
  tl_fifo_channel #(.W(d_w), .DEPTH(GntDepth), .FALL_THROUGH(GntFallThrough)) u_gnt (
    .clk_i, .rst_ni,
    .w_valid(device_d_valid), .w_ready(device_d_ready), .w_data(device_d),
    .r_valid(host_d_valid), .r_ready(host_d_ready), .r_data(host_d),
    .count(gnt_count_o)
`ifdef TL_FIFO_WATERMARK_EN
    , .hwm_clear(hwm_clear_i), .hwm(gnt_hwm_o)
`endif
  );
  tl_fifo_channel #(.W(e_w), .DEPTH(AckDepth), .FALL_THROUGH(AckFallThrough)) u_ack (
    .clk_i, .rst_ni,
    .w_valid(host_e_valid), .w_ready(host_e_ready), .w_data(host_e),
    .r_valid(device_e_valid), .r_ready(device_e_ready), .r_data(device_e),
    .count(ack_count_o)
`ifdef TL_FIFO_WATERMARK_EN
    , .hwm_clear(hwm_clear_i), .hwm(ack_hwm_o)
`endif
  );
endmodule

// File: tb/tb_tl_fifo.sv
// tb_tl_fifo: scoreboard bench for tl_fifo (Req=3, Rel=2, Gnt=4, Ack=2 fall-through)
module tb_tl_fifo;
  import tl_fifo_pkg::*;
  localparam int aw = tl_a_w(1, 56, 64);
  localparam int bw = tl_b_w(1, 56, 64);
  localparam int cw = tl_c_w(1, 56, 64);
  localparam int dw = tl_d_w(1, 1, 64);
  localparam int ew = tl_e_w(1);
  logic clk_i = 0, rst_ni = 0;
  logic host_a_valid = 0, host_a_ready, host_b_valid, host_b_ready = 1;
  logic host_c_valid = 0, host_c_ready, host_d_valid, host_d_ready = 0;
  logic host_e_valid = 0, host_e_ready;
  logic device_a_valid, device_a_ready = 1, device_b_valid = 0, device_b_ready;
  logic device_c_valid, device_c_ready = 1, device_d_valid = 0, device_d_ready;
  logic device_e_valid, device_e_ready = 1;
  logic [aw-1:0] host_a = '0, device_a;
  logic [bw-1:0] host_b, device_b = '0;
  logic [cw-1:0] host_c = '0, device_c;
  logic [dw-1:0] host_d, device_d = '0;
  logic [ew-1:0] host_e = '0, device_e;
  logic [1:0] req_count_o, rel_count_o, ack_count_o, prb_count_o;
  logic [2:0] gnt_count_o;
`ifdef TL_FIFO_WATERMARK_EN
  logic hwm_clear_i = 0;
  logic [1:0] req_hwm_o, prb_hwm_o, rel_hwm_o, ack_hwm_o;
  logic [2:0] gnt_hwm_o;
`endif
  logic [255:0] qa[$], qc[$], qd[$], qe[$];
  int checks = 0, errors = 0;

  tl_fifo #(.ReqDepth(3), .RelDepth(2), .GntDepth(4), .AckDepth(2), .AckFallThrough(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_a_valid(host_a_valid), .host_a(host_a), .host_a_ready(host_a_ready),
    .host_b_valid(host_b_valid), .host_b(host_b), .host_b_ready(host_b_ready),
    .host_c_valid(host_c_valid), .host_c(host_c), .host_c_ready(host_c_ready),
    .host_d_valid(host_d_valid), .host_d(host_d), .host_d_ready(host_d_ready),
    .host_e_valid(host_e_valid), .host_e(host_e), .host_e_ready(host_e_ready),
    .device_a_valid(device_a_valid), .device_a(device_a), .device_a_ready(device_a_ready),
    .device_b_valid(device_b_valid), .device_b(device_b), .device_b_ready(device_b_ready),
    .device_c_valid(device_c_valid), .device_c(device_c), .device_c_ready(device_c_ready),
    .device_d_valid(device_d_valid), .device_d(device_d), .device_d_ready(device_d_ready),
    .device_e_valid(device_e_valid), .device_e(device_e), .device_e_ready(device_e_ready),
    .req_count_o(req_count_o), .prb_count_o(prb_count_o), .rel_count_o(rel_count_o),
    .gnt_count_o(gnt_count_o), .ack_count_o(ack_count_o)
`ifdef TL_FIFO_WATERMARK_EN
    , .hwm_clear_i(hwm_clear_i), .req_hwm_o(req_hwm_o), .prb_hwm_o(prb_hwm_o),
    .rel_hwm_o(rel_hwm_o), .gnt_hwm_o(gnt_hwm_o), .ack_hwm_o(ack_hwm_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic unexp(input string n, input logic [255:0] got);
    checks++;
    errors++;
    $display("FAIL %s unexpected beat got %0h expected none", n, got);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Monitor: pops the scoreboard on every output handshake
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (device_a_valid && device_a_ready) begin
        if (qa.size() == 0) unexp("req", 256'(device_a)); else chk("req", 256'(device_a), qa.pop_front());
      end
      if (device_c_valid && device_c_ready) begin
        if (qc.size() == 0) unexp("rel", 256'(device_c)); else chk("rel", 256'(device_c), qc.pop_front());
      end
      if (host_d_valid && host_d_ready) begin
        if (qd.size() == 0) unexp("gnt", 256'(host_d)); else chk("gnt", 256'(host_d), qd.pop_front());
      end
      if (device_e_valid && device_e_ready) begin
        if (qe.size() == 0) unexp("ack", 256'(device_e)); else chk("ack", 256'(device_e), qe.pop_front());
      end
      if (req_count_o > 2'd3) chk("req_count_bound", 256'(req_count_o), 256'(3));
    end
  end

  task automatic push_a(input logic [aw-1:0] v);
    bit ok = 0;
    host_a_valid = 1;
    host_a = v;
    qa.push_back(256'(v));
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk_i);
      ok = host_a_ready;
    end
    if (!ok) chk("req_push_timeout", 0, 1);
    @(posedge clk_i);
    #1;
    host_a_valid = 0;
  endtask

  task automatic push_c(input logic [cw-1:0] v);
    bit ok = 0;
    host_c_valid = 1;
    host_c = v;
    qc.push_back(256'(v));
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk_i);
      ok = host_c_ready;
    end
    if (!ok) chk("rel_push_timeout", 0, 1);
    @(posedge clk_i);
    #1;
    host_c_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_req_count", 256'(req_count_o), 0);
    chk("rst_gnt_count", 256'(gnt_count_o), 0);
    chk("rst_valids", 256'({device_a_valid, host_b_valid, device_c_valid, host_d_valid, device_e_valid}), 0);
    chk("rst_host_a_ready", 256'(host_a_ready), 1);
    cyc(2);
    rst_ni = 1;
    cyc(1);
    // Grant burst held back, then released in order on consecutive cycles
    for (int i = 1; i <= 4; i++) begin
      device_d_valid = 1;
      device_d = dw'(8'h11 * i);
      qd.push_back(256'(8'h11 * i));
      cyc(1);
    end
    device_d_valid = 0;
    chk("gnt_count_full", 256'(gnt_count_o), 4);
    chk("gnt_w_ready_full", 256'(device_d_ready), 0);
    chk("gnt_r_valid_full", 256'(host_d_valid), 1);
    host_d_ready = 1;
    cyc(4);
    chk("gnt_count_drained", 256'(gnt_count_o), 0);
    chk("gnt_sb_empty", 256'(qd.size()), 0);
    // Depth-3 request stream with random back-pressure
    fork
      for (int i = 0; i < 10; i++) push_a(aw'(8'hA0 + i));
      repeat (40) begin
        @(posedge clk_i);
        #1;
        device_a_ready = 1'($urandom_range(0, 1));
      end
    join
    device_a_ready = 1;
    cyc(5);
    chk("req_sb_empty", 256'(qa.size()), 0);
    chk("req_count_drained", 256'(req_count_o), 0);
    // Fall-through ack: visible in the same cycle, never stored
    host_e_valid = 1;
    host_e = 1'b1;
    qe.push_back(256'(1));
    @(negedge clk_i);
    chk("ack_ft_valid", 256'(device_e_valid), 1);
    chk("ack_ft_data", 256'(device_e), 1);
    chk("ack_ft_count", 256'(ack_count_o), 0);
    cyc(1);
    host_e_valid = 0;
    chk("ack_ft_count_after", 256'(ack_count_o), 0);
    chk("ack_sb_empty", 256'(qe.size()), 0);
    // Release full: pop happens while the push is refused
    device_c_ready = 0;
    push_c(cw'(8'hC1));
    push_c(cw'(8'hC2));
    chk("rel_count_full", 256'(rel_count_o), 2);
    chk("rel_ready_full", 256'(host_c_ready), 0);
    device_c_ready = 1;
    host_c_valid = 1;
    host_c = cw'(8'hC3);
    @(negedge clk_i);
    chk("rel_ready_pop_cycle", 256'(host_c_ready), 0);
    cyc(1);
    host_c_valid = 0;
    chk("rel_count_after_pop", 256'(rel_count_o), 1);
    push_c(cw'(8'hC3));
    cyc(3);
    chk("rel_sb_empty", 256'(qc.size()), 0);
    chk("rel_count_drained", 256'(rel_count_o), 0);
    // Asynchronous reset with three beats stored
    device_a_ready = 0;
    push_a(aw'(8'h51));
    push_a(aw'(8'h52));
    push_a(aw'(8'h53));
    chk("req_count_pre_rst", 256'(req_count_o), 3);
    #2;
    rst_ni = 0;
    #1;
    chk("arst_req_count", 256'(req_count_o), 0);
    chk("arst_req_valid", 256'(device_a_valid), 0);
    qa.delete();
    cyc(1);
    rst_ni = 1;
    device_a_ready = 1;
    push_a(aw'(8'h61));
    cyc(3);
    chk("post_rst_sb_empty", 256'(qa.size()), 0);
`ifdef TL_FIFO_WATERMARK_EN
    device_a_ready = 0;
    push_a(aw'(8'h71));
    push_a(aw'(8'h72));
    push_a(aw'(8'h73));
    device_a_ready = 1;
    cyc(4);
    chk("req_hwm_peak", 256'(req_hwm_o), 3);
    chk("req_hwm_count", 256'(req_count_o), 0);
    hwm_clear_i = 1;
    cyc(1);
    hwm_clear_i = 0;
    chk("req_hwm_cleared", 256'(req_hwm_o), 0);
`endif
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tl_fifo.md
Name: tl_fifo

Overview:
- Parametrised successor to the TileLink register slice. Each of the five TL channels (A–E) gets an independent buffer.
- Per-channel depth is configurable: 0 = wire, 1..N = circular FIFO. Each channel can also be configured for fall-through.
- Sits between any TL host/device pair: CDC-free crossbar stages, cache-to-memory links, and decoupling of long Grant bursts from Release traffic.
- Reports live per-channel occupancy for performance counters.

Parameters:
- SourceWidth, 1, TL source ID width
- SinkWidth, 1, TL sink ID width
- AddrWidth, 56, address width
- DataWidth, 64, data beat width
- ReqDepth / PrbDepth / RelDepth / GntDepth / AckDepth, 2, entries for channels A/B/C/D/E; 0 = combinational bypass
- ReqFallThrough / PrbFallThrough / RelFallThrough / GntFallThrough / AckFallThrough, 0, 1 = write data visible on read side in the same cycle when empty

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- host_{a,c,e}_valid / host_{a,c,e}  input  1 / channel struct  host-side requests into block
- host_{a,c,e}_ready  output  1  host-side accept
- host_{b,d}_valid / host_{b,d}  output  1 / channel struct  host-side responses out of block
- host_{b,d}_ready  input  1
- device_{a,c,e}_valid / device_{a,c,e}  output  1 / channel struct  device-side requests
- device_{a,c,e}_ready  input  1
- device_{b,d}_valid / device_{b,d}  input  1 / channel struct
- device_{b,d}_ready  output  1
- {req,prb,rel,gnt,ack}_count_o  output  $clog2(Depth+1) each (min 1)  current occupancy

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Each channel is one tl_fifo_channel with push side (w_valid/w_ready/w_data) and pop side (r_valid/r_ready/r_data).
- Depth=0: r_valid=w_valid, w_ready=r_ready, r_data=w_data; count tied to 0; FallThrough ignored.
- Depth≥1 storage: D-entry array; rd_ptr and wr_ptr each wrap from D-1 to 0 (non-power-of-two D supported); count of 0..D.
- Depth≥1 handshake rules:
  - w_ready = (count != D). Registered only; never depends on r_ready, so the reverse path is cut.
  - r_valid = (count != 0), or with FallThrough: (count != 0) | w_valid.
  - r_data = mem[rd_ptr], or when FallThrough and count==0: w_data.
- Push = w_valid & w_ready; pop = r_valid & r_ready.
  - Fall-through with push & pop while count==0: no write, count unchanged.
  - Otherwise count += push − pop.
  - Simultaneous push & pop with 0<count<D: both pointers advance, count constant.
  - Full (count==D): push blocked even if pop occurs that cycle.
- Latency: non-fall-through is 1 cycle from accepted push to r_valid. Fall-through is 0 cycles.
- Throughput: 1 beat/cycle per channel for D≥2. D=1 non-fall-through gives 1 beat per 2 cycles.
- Ordering: strict FIFO per channel; no cross-channel ordering is imposed; multi-beat bursts are never split or reordered.
- Reset: pointers and counts go to 0; all *_valid outputs to 0; w_ready=1 for D≥1. Reset mid-operation discards stored beats immediately (asynchronous); storage array is not reset.
- Stability: r_data is held stable while r_valid & !r_ready (guaranteed by storage). The block never drops valid before a handshake.

Optional Feature:
- Macro TL_FIFO_WATERMARK_EN.
- Defined:
  - Adds {req,prb,rel,gnt,ack}_hwm_o (same width as count). Each is a register updated to max(hwm, next count) every cycle and reset to 0.
  - Adds input hwm_clear_i (1 bit): synchronous clear to the current count, which takes priority over the max update.
- Undefined: hwm ports and hwm_clear_i are absent; no extra flops.

Decomposition:
- tl_pkg: no new types needed; channel structs come from the existing TL_*_STRUCT macros.
- Add localparam helper function tl_fifo_cnt_w(depth) to tl_pkg.
- Sub-module tl_fifo_channel, parametrised by TYPE, DEPTH, FALL_THROUGH.
  - Five instances in tl_fifo; B and D are instantiated in the device→host direction.
  - Watermark logic lives inside tl_fifo_channel under the macro.

Test Plan:
- GntDepth=4, no fall-through: push 4 beats (d_data 0x11..0x44) with host_d_ready=0 → gnt_count_o=4, device_d_ready=0; release ready → 0x11,0x22,0x33,0x44 in order on consecutive cycles.
- ReqDepth=3 (non-power-of-two): stream 10 beats with random ready → output order matches input, count never >3, pointers wrap cleanly.
- AckFallThrough=1, AckDepth=2, empty, host_e_valid & device_e_ready same cycle → device_e_valid and data seen in cycle 0, ack_count_o stays 0.
- RelDepth=2 full, simultaneous pop and push attempt → pop completes, host_c_ready=0 that cycle, rel_count_o=1 next cycle.
- Assert rst_ni low mid-burst with count=3 → all valids 0 and counts 0 asynchronously; first post-reset push emerges as first output.
- With TL_FIFO_WATERMARK_EN: fill req to 3, drain → req_hwm_o=3; pulse hwm_clear_i at count 0 → req_hwm_o=0.
